// File: rtl/memory_unit_sync_pkg.sv
// ---------------------------------------------------------------------------
// mem_unit_pkg
// Shared types and helpers for memory_unit_sync and its address decoder.
//   state_e      : controller states (sweep-clear / idle)
//   OP_READ/WRITE: encodings of the op request bit
//   even_parity  : even-parity bit over a data word (zero-extended to
//                  PAR_MAX_W bits, so words up to 64 bits are supported)
// ---------------------------------------------------------------------------
package mem_unit_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int PAR_MAX_W = 64;

   // Zero-extension does not change the XOR, so callers cast narrower words up.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/memory_unit_sync_addr_decoder.sv
// ---------------------------------------------------------------------------
// mem_addr_decoder
// Turns a word address plus an enable into a one-hot per-word write enable
// and flags addresses that fall beyond the populated depth.
//   i_address      in  ADDR_W  word address
//   i_en           in  1       qualify the write enable
//   o_we           out DEPTH   one-hot write enable (all zero if out of range)
//   o_out_of_range out 1       address >= DEPTH (independent of i_en)
// ---------------------------------------------------------------------------
module mem_addr_decoder
   import mem_unit_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_en,
   output logic [DEPTH-1:0]  o_we,
   output logic              o_out_of_range
);

   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   assign o_out_of_range = ({1'b0, i_address} >= DEPTH_V);

   always_comb begin
      o_we = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_en && (i_address == ADDR_W'(i))) begin
            o_we[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_unit_sync.sv
// ---------------------------------------------------------------------------
// memory_unit_sync
// DEPTH x WIDTH scratch memory with a single-port request interface, a
// one-cycle registered read path and a hardware clear sweep that zeroes the
// array after reset or on request.
// Optional build macro: MEM_UNIT_PARITY_EN adds one even-parity bit per word
// (parity builds support WIDTH up to 64).
//
// Ports:
//   clk         in  1       clock, rising edge
//   rst_n       in  1       synchronous active-low reset
//   select      in  1       request strobe, accepted only when ready
//   op          in  1       1 = write, 0 = read
//   address     in  ADDR_W  word address
//   in_bus      in  WIDTH   write data
//   clear       in  1       start a full-array clear (honoured in IDLE)
//   par_flip    in  1       store inverted parity on this write (parity build)
//   out_bus     out WIDTH   registered read data, held between reads
//   valid_out   out 1       pulse: out_bus carries new read data
//   addr_err    out 1       pulse: accepted request addressed >= DEPTH
//   parity_err  out 1       pulse with valid_out on stored parity mismatch
//   ready       out 1       requests are accepted
//   busy        out 1       clear sweep in progress
//
// state    | meaning
// ST_CLEAR | sweeping zeros into mem[clr_cnt], requests ignored
// ST_IDLE  | accepting read/write requests or a clear command
// ---------------------------------------------------------------------------
module memory_unit_sync
   import mem_unit_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              select,
   input  logic              op,
   input  logic [ADDR_W-1:0] address,
   input  logic [WIDTH-1:0]  in_bus,
   input  logic              clear,
   input  logic              par_flip,
   output logic [WIDTH-1:0]  out_bus,
   output logic              valid_out,
   output logic              addr_err,
   output logic              parity_err,
   output logic              ready,
   output logic              busy
);

`ifdef MEM_UNIT_PARITY_EN
   localparam int MEM_W = WIDTH + 1;
`else
   localparam int MEM_W = WIDTH;
`endif

   state_e            r_state;
   state_e            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic              w_clr_last;
   logic              w_busy;
   logic              w_ready;

   logic [MEM_W-1:0]  r_mem [DEPTH];
   logic [MEM_W-1:0]  w_wr_word;
   logic [MEM_W-1:0]  w_rd_word;

   logic              w_accept;
   logic              w_rd_req;
   logic              w_wr_req;
   logic [DEPTH-1:0]  w_we;
   logic              w_oor;

   logic [WIDTH-1:0]  r_out_bus;
   logic              r_valid_out;
   logic              r_addr_err;

   assign w_clr_last = (r_clr_cnt == ADDR_W'(DEPTH-1));

   // clear wins over a same-cycle select; that request is simply dropped
   assign w_accept = select & w_ready & ~clear;
   assign w_rd_req = w_accept & (op == OP_READ);
   assign w_wr_req = w_accept & (op == OP_WRITE);

   mem_addr_decoder #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_dec (
      .i_address      (address),
      .i_en           (w_wr_req),
      .o_we           (w_we),
      .o_out_of_range (w_oor)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
         ST_IDLE:  if (clear)      w_state_nxt = ST_CLEAR;
         default:                  w_state_nxt = ST_CLEAR;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_busy  = 1'b0;
      w_ready = 1'b0;
      case (r_state)
         ST_CLEAR: w_busy  = 1'b1;
         ST_IDLE:  w_ready = 1'b1;
         default:  w_busy  = 1'b1;
      endcase
   end

   assign busy  = w_busy;
   assign ready = w_ready;

   // Sweep counter; parked at 0 outside the sweep so a new clear starts at word 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clr_cnt <= '0;
      end else if ((r_state == ST_CLEAR) && !w_clr_last) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
      end else begin
         r_clr_cnt <= '0;
      end
   end

`ifdef MEM_UNIT_PARITY_EN
   assign w_wr_word = {even_parity(PAR_MAX_W'(in_bus)) ^ par_flip, in_bus};
`else
   assign w_wr_word = in_bus;
   logic w_unused_par_flip;
   assign w_unused_par_flip = par_flip;
`endif

   // Storage is not reset; the sweep writes all-zero words, whose even parity is 0.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((r_state == ST_CLEAR) && (r_clr_cnt == ADDR_W'(i))) begin
               r_mem[i] <= '0;
            end else if (w_we[i]) begin
               r_mem[i] <= w_wr_word;
            end
         end
      end
   end

   // Explicit compare loop keeps the read away from unpopulated indices.
   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) begin
            w_rd_word = r_mem[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_bus   <= '0;
         r_valid_out <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         r_valid_out <= w_rd_req;
         r_addr_err  <= w_accept & w_oor;
         if (w_rd_req) begin
            r_out_bus <= w_oor ? '0 : w_rd_word[WIDTH-1:0];
         end
      end
   end

`ifdef MEM_UNIT_PARITY_EN
   logic r_parity_err;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_rd_req & ~w_oor &
                         (w_rd_word[WIDTH] != even_parity(PAR_MAX_W'(w_rd_word[WIDTH-1:0])));
      end
   end
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign out_bus   = r_out_bus;
   assign valid_out = r_valid_out;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_memory_unit_sync.sv
module tb_memory_unit_sync;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 6;

   logic              clk;
   logic              rst_n;
   logic              select;
   logic              op;
   logic [ADDR_W-1:0] address;
   logic [WIDTH-1:0]  in_bus;
   logic              clear;
   logic              par_flip;
   logic [WIDTH-1:0]  out_bus;
   logic              valid_out;
   logic              addr_err;
   logic              parity_err;
   logic              ready;
   logic              busy;

   memory_unit_sync #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .select     (select),
      .op         (op),
      .address    (address),
      .in_bus     (in_bus),
      .clear      (clear),
      .par_flip   (par_flip),
      .out_bus    (out_bus),
      .valid_out  (valid_out),
      .addr_err   (addr_err),
      .parity_err (parity_err),
      .ready      (ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             valid;
      logic [WIDTH-1:0] data;
      logic             aerr;
      logic             perr;
   } exp_t;

   exp_t             q[$];
   exp_t             mon_e;
   int               checks;
   int               failures;
   logic             mon_en;

   // reference model: word contents, parity-flip marks, remaining sweep cycles
   logic [WIDTH-1:0] m_mem  [1 << ADDR_W];
   logic             m_flip [1 << ADDR_W];
   int               clr_left;
   logic [WIDTH-1:0] exp_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Applies the request rules to the inputs present at this rising edge.
   task automatic model_step();
      exp_t e;
      if (!rst_n) begin
         clr_left = DEPTH;
         exp_hold = '0;
         for (int i = 0; i < (1 << ADDR_W); i++) begin
            m_mem[i]  = '0;
            m_flip[i] = 1'b0;
         end
      end else if (clr_left > 0) begin
         clr_left--;
      end else if (clear) begin
         clr_left = DEPTH;
         for (int i = 0; i < (1 << ADDR_W); i++) begin
            m_mem[i]  = '0;
            m_flip[i] = 1'b0;
         end
      end else if (select) begin
         if (int'(address) >= DEPTH) begin
            e.valid = ~op;
            e.data  = '0;
            e.aerr  = 1'b1;
            e.perr  = 1'b0;
            q.push_back(e);
            if (!op) exp_hold = '0;
         end else if (op) begin
            m_mem[address]  = in_bus;
            m_flip[address] = par_flip;
         end else begin
            e.valid = 1'b1;
            e.data  = m_mem[address];
            e.aerr  = 1'b0;
`ifdef MEM_UNIT_PARITY_EN
            e.perr  = m_flip[address];
`else
            e.perr  = 1'b0;
`endif
            q.push_back(e);
            exp_hold = e.data;
         end
      end
   endtask

   task automatic cyc(input logic rn, input logic sel, input logic o,
                      input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                      input logic pf, input logic clr);
      rst_n    = rn;
      select   = sel;
      op       = o;
      address  = a;
      in_bus   = d;
      par_flip = pf;
      clear    = clr;
      @(posedge clk);
      model_step();
      #1;
      chk("ready", ready, (clr_left == 0));
      chk("busy", busy, (clr_left != 0));
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic pf);
      cyc(1'b1, 1'b1, 1'b1, a, d, pf, 1'b0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a);
      cyc(1'b1, 1'b1, 1'b0, a, '0, 1'b0, 1'b0);
   endtask

   task automatic count_busy(input string name);
      int n;
      n = 0;
      for (int k = 0; k < 4 * DEPTH && busy; k++) begin
         n++;
         idle();
      end
      chk(name, n, DEPTH);
   endtask

   // monitor: any output pulse consumes one expected response
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (q.size() > 0 || valid_out || addr_err) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: valid_out=%0b addr_err=%0b expected no response",
                           valid_out, addr_err);
               end else begin
                  mon_e = q.pop_front();
                  chk("valid_out", valid_out, mon_e.valid);
                  chk("addr_err", addr_err, mon_e.aerr);
                  chk("parity_err", parity_err, mon_e.perr);
                  if (mon_e.valid) chk("out_bus", out_bus, mon_e.data);
               end
            end else begin
               chk("out_hold", out_bus, exp_hold);
               chk("parity_quiet", parity_err, 1'b0);
            end
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      mon_en   = 1'b0;
      clr_left = DEPTH;
      exp_hold = '0;

      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("rst_out_bus", out_bus, '0);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_addr_err", addr_err, 1'b0);
      chk("rst_parity_err", parity_err, 1'b0);
      mon_en = 1'b1;

      rst_n = 1'b1;
      count_busy("busy_after_reset");

      for (int a = 0; a < (1 << ADDR_W); a++) rd(ADDR_W'(a));

      wr(3'd3, 8'hA5, 1'b0);
      rd(3'd3);
      idle();

      wr(3'd7, 8'hFF, 1'b0);
      rd(3'd7);
      rd(3'd5);
      idle();

      cyc(1'b1, 1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b1);
      count_busy("busy_after_clear");
      rd(3'd1);

      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      idle();
      idle();
      idle();
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      count_busy("busy_after_midclear_reset");

      wr(3'd2, 8'h0F, 1'b1);
      rd(3'd2);
      wr(3'd2, 8'h0F, 1'b0);
      rd(3'd2);
      idle();

      for (int k = 0; k < 400; k++) begin
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)), WIDTH'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      end

      for (int k = 0; k < 2 * DEPTH; k++) idle();
      chk("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
